// File: rtl/exec_logic_arbiter_pkg.sv
// rtl/exec_logic_arbiter_pkg.sv - shared op encodings, widths and requester IDs
package exec_logic_arbiter_pkg;

  localparam int W_OPR_DEF = 32;
  localparam int W_TAG_DEF = 4;
  localparam int W_CNT_DEF = 16;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_NOT = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/exec_logic_arbiter_if.sv
// rtl/exec_logic_arbiter_if.sv - two issue requesters plus the result channel
interface exec_logic_arbiter_if
  import exec_logic_arbiter_pkg::*;
#(
  parameter int W_OPR = W_OPR_DEF,
  parameter int W_TAG = W_TAG_DEF
);
  logic             req0_valid_i;
  logic             req0_ready_o;
  logic [W_OPR-1:0] req0_opr0_i;
  logic [W_OPR-1:0] req0_opr1_i;
  logic [1:0]       req0_select_i;
  logic [W_TAG-1:0] req0_tag_i;

  logic             req1_valid_i;
  logic             req1_ready_o;
  logic [W_OPR-1:0] req1_opr0_i;
  logic [W_OPR-1:0] req1_opr1_i;
  logic [1:0]       req1_select_i;
  logic [W_TAG-1:0] req1_tag_i;

  logic             res_valid_o;
  logic             res_ready_i;
  logic [W_OPR-1:0] res_data_o;
  logic [W_TAG-1:0] res_tag_o;
  logic             res_src_o;

  modport slave (
    input  req0_valid_i, req0_opr0_i, req0_opr1_i, req0_select_i, req0_tag_i,
    output req0_ready_o,
    input  req1_valid_i, req1_opr0_i, req1_opr1_i, req1_select_i, req1_tag_i,
    output req1_ready_o,
    output res_valid_o, res_data_o, res_tag_o, res_src_o,
    input  res_ready_i
  );

  modport master (
    output req0_valid_i, req0_opr0_i, req0_opr1_i, req0_select_i, req0_tag_i,
    input  req0_ready_o,
    output req1_valid_i, req1_opr0_i, req1_opr1_i, req1_select_i, req1_tag_i,
    input  req1_ready_o,
    input  res_valid_o, res_data_o, res_tag_o, res_src_o,
    output res_ready_i
  );

endinterface

// File: rtl/exec_logic_arbiter_exec_logic.sv
// rtl/exec_logic_arbiter_exec_logic.sv - combinational AND/OR/NOT/XOR unit
module exec_logic_arbiter_exec_logic
  import exec_logic_arbiter_pkg::*;
#(
  parameter int W_OPR = W_OPR_DEF
) (
  input  logic [W_OPR-1:0] opr0_i,
  input  logic [W_OPR-1:0] opr1_i,
  input  logic [1:0]       select_i,
  output logic [W_OPR-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_e'(select_i))
      OP_AND: result_o = opr0_i & opr1_i;
      OP_OR:  result_o = opr0_i | opr1_i;
      OP_NOT: result_o = ~opr0_i;
      OP_XOR: result_o = opr0_i ^ opr1_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/exec_logic_arbiter.sv
// rtl/exec_logic_arbiter.sv - round-robin sharing of one exec_logic unit between two
// requesters, with a one-entry result register and saturating grant counters
module exec_logic_arbiter
  import exec_logic_arbiter_pkg::*;
#(
  parameter int W_OPR = W_OPR_DEF,
  parameter int W_TAG = W_TAG_DEF,
  parameter int W_CNT = W_CNT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  exec_logic_arbiter_if.slave  bus,
  input  logic                 cnt_clr_i,
  output logic [W_CNT-1:0]     cnt0_o,
  output logic [W_CNT-1:0]     cnt1_o
);

  logic             res_valid_q, res_valid_d;
  logic [W_OPR-1:0] res_data_q,  res_data_d;
  logic [W_TAG-1:0] res_tag_q,   res_tag_d;
  logic             res_src_q,   res_src_d;
  logic             rr_q,        rr_d;
  logic [W_CNT-1:0] cnt0_q,      cnt0_d;
  logic [W_CNT-1:0] cnt1_q,      cnt1_d;

  logic             can_accept;
  logic             both_valid;
  logic             grant;
  logic             ready0, ready1;
  logic             accept;
  logic [W_OPR-1:0] mux_opr0, mux_opr1;
  logic [1:0]       mux_select;
  logic [W_TAG-1:0] mux_tag;
  logic [W_OPR-1:0] exec_result;

  // A full register that drains this cycle can take a new op in the same cycle.
  assign can_accept = ~res_valid_q | bus.res_ready_i;
  assign both_valid = bus.req0_valid_i & bus.req1_valid_i;

  always_comb begin
    grant = REQ0;
    if (both_valid)
      grant = rr_q;
    else if (bus.req1_valid_i)
      grant = REQ1;
  end

  // rst_n gating keeps both readies low for the whole reset window.
  assign ready0 = rst_n & can_accept & (grant == REQ0);
  assign ready1 = rst_n & can_accept & (grant == REQ1);
  assign bus.req0_ready_o = ready0;
  assign bus.req1_ready_o = ready1;

  assign accept = (bus.req0_valid_i & ready0) | (bus.req1_valid_i & ready1);

  assign mux_opr0   = (grant == REQ1) ? bus.req1_opr0_i   : bus.req0_opr0_i;
  assign mux_opr1   = (grant == REQ1) ? bus.req1_opr1_i   : bus.req0_opr1_i;
  assign mux_select = (grant == REQ1) ? bus.req1_select_i : bus.req0_select_i;
  assign mux_tag    = (grant == REQ1) ? bus.req1_tag_i    : bus.req0_tag_i;

  exec_logic_arbiter_exec_logic #(
    .W_OPR (W_OPR)
  ) u_exec_logic (
    .opr0_i   (mux_opr0),
    .opr1_i   (mux_opr1),
    .select_i (mux_select),
    .result_o (exec_result)
  );

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    res_src_d   = res_src_q;
    rr_d        = rr_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;

    if (accept) begin
      res_valid_d = 1'b1;
      res_data_d  = exec_result;
      res_tag_d   = mux_tag;
      res_src_d   = grant;
    end else if (bus.res_ready_i) begin
      res_valid_d = 1'b0;
    end

    // The pointer only moves on contention, so a lone requester never loses priority.
    if (accept && both_valid)
      rr_d = ~grant;

    if (cnt_clr_i) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else if (accept) begin
      if (grant == REQ0 && cnt0_q != '1)
        cnt0_d = cnt0_q + W_CNT'(1);
      if (grant == REQ1 && cnt1_q != '1)
        cnt1_d = cnt1_q + W_CNT'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      res_src_q   <= REQ0;
      rr_q        <= REQ0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      res_src_q   <= res_src_d;
      rr_q        <= rr_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign bus.res_valid_o = res_valid_q;
  assign bus.res_data_o  = res_data_q;
  assign bus.res_tag_o   = res_tag_q;
  assign bus.res_src_o   = res_src_q;
  assign cnt0_o          = cnt0_q;
  assign cnt1_o          = cnt1_q;

endmodule

// File: tb/tb_exec_logic_arbiter.sv
// tb/tb_exec_logic_arbiter.sv - randomized and directed bench against a behavioural model
module tb_exec_logic_arbiter;
  import exec_logic_arbiter_pkg::*;

  localparam int W_OPR = 32;
  localparam int W_TAG = 4;
  localparam int W_CNT = 2;
  localparam int CMAX  = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cnt_clr_i = 1'b0;
  logic [W_CNT-1:0] cnt0_o, cnt1_o;

  exec_logic_arbiter_if #(.W_OPR(W_OPR), .W_TAG(W_TAG)) bus ();

  exec_logic_arbiter #(.W_OPR(W_OPR), .W_TAG(W_TAG), .W_CNT(W_CNT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .cnt_clr_i (cnt_clr_i),
    .cnt0_o    (cnt0_o),
    .cnt1_o    (cnt1_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        m_valid, m_src, m_pref, acc0, acc1;
  logic [31:0] m_data;
  logic [3:0]  m_tag;
  int          m_cnt0, m_cnt1;

  function automatic logic [31:0] ref_op(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return ~a;
      default: return a ^ b;
    endcase
  endfunction

  // Who wins: the lone requester, or under contention whoever did not win the last contended round.
  function automatic logic mdl_winner();
    if (bus.req0_valid_i && bus.req1_valid_i) return m_pref;
    return bus.req1_valid_i && !bus.req0_valid_i;
  endfunction

  function automatic logic exp_ready(input logic n);
    return rst_n && (!m_valid || bus.res_ready_i) && (mdl_winner() == n);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_tag = 0; m_src = 0; m_pref = 0;
    m_cnt0 = 0; m_cnt1 = 0; acc0 = 0; acc1 = 0;
  endtask

  task automatic drive(input logic n, input logic v, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    if (n == 1'b0) begin
      bus.req0_valid_i = v; bus.req0_select_i = s; bus.req0_opr0_i = a;
      bus.req0_opr1_i = b; bus.req0_tag_i = t;
    end else begin
      bus.req1_valid_i = v; bus.req1_select_i = s; bus.req1_opr0_i = a;
      bus.req1_opr1_i = b; bus.req1_tag_i = t;
    end
  endtask

  // Advance one clock and let the model absorb the transfer seen at that edge.
  task automatic tick();
    logic v0, v1, g, acc, clr, rdy;
    logic [31:0] d;
    logic [3:0] t;
    v0 = bus.req0_valid_i; v1 = bus.req1_valid_i;
    g = mdl_winner();
    acc = rst_n && (v0 || v1) && (!m_valid || bus.res_ready_i);
    d = g ? ref_op(bus.req1_select_i, bus.req1_opr0_i, bus.req1_opr1_i)
          : ref_op(bus.req0_select_i, bus.req0_opr0_i, bus.req0_opr1_i);
    t = g ? bus.req1_tag_i : bus.req0_tag_i;
    clr = cnt_clr_i; rdy = bus.res_ready_i;
    @(posedge clk);
    acc0 = acc && !g;
    acc1 = acc && g;
    if (acc) begin
      m_valid = 1; m_data = d; m_tag = t; m_src = g;
      if (v0 && v1) m_pref = !g;
    end else if (rdy) begin
      m_valid = 0;
    end
    if (clr) begin
      m_cnt0 = 0; m_cnt1 = 0;
    end else begin
      if (acc0 && m_cnt0 < CMAX) m_cnt0++;
      if (acc1 && m_cnt1 < CMAX) m_cnt1++;
    end
    @(negedge clk);
  endtask

  task automatic idle_clear();
    drive(0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
    bus.res_ready_i = 1; cnt_clr_i = 1;
    tick();
    cnt_clr_i = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; model_reset();
    drive(0, 1, 2'b00, 32'h1, 32'h1, 4'h1); drive(1, 0, 0, 0, 0, 0);
    bus.res_ready_i = 0;
    @(negedge clk);
    total++; if (bus.res_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.res_valid_o); end
    total++; if (bus.res_data_o !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", bus.res_data_o); end
    total++; if ({bus.res_tag_o, bus.res_src_o} !== 5'h0) begin bad++; $display("FAIL reset_tag_src got=%h want=0", {bus.res_tag_o, bus.res_src_o}); end
    total++; if ({cnt0_o, cnt1_o} !== 4'h0) begin bad++; $display("FAIL reset_cnt got=%h want=0", {cnt0_o, cnt1_o}); end
    total++; if ({bus.req0_ready_o, bus.req1_ready_o} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", {bus.req0_ready_o, bus.req1_ready_o}); end
    rst_n = 1;
    tick(); tick();
    total++; if (bus.res_valid_o !== 1'b1 || cnt0_o !== 2'd1) begin bad++; $display("FAIL pre_reset_fill valid=%0b cnt0=%0d want 1/1", bus.res_valid_o, cnt0_o); end
    rst_n = 0; #1;
    model_reset();
    total++; if (bus.res_valid_o !== 1'b0 || cnt0_o !== 2'd0 || cnt1_o !== 2'd0) begin bad++; $display("FAIL midreset_clear valid=%0b cnt0=%0d cnt1=%0d want 0", bus.res_valid_o, cnt0_o, cnt1_o); end
    total++; if ({bus.req0_ready_o, bus.req1_ready_o} !== 2'b00) begin bad++; $display("FAIL midreset_ready got=%b want=00", {bus.req0_ready_o, bus.req1_ready_o}); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0); drive(1, 1, 2'b01, 32'h00F0, 32'h0F00, 4'h9);
    bus.res_ready_i = 1;
    rst_n = 1; #1;
    total++; if ({bus.req0_ready_o, bus.req1_ready_o} !== 2'b01) begin bad++; $display("FAIL post_reset_ready got=%b want=01", {bus.req0_ready_o, bus.req1_ready_o}); end
    tick();
    total++; if (bus.res_valid_o !== 1'b1 || bus.res_src_o !== 1'b1 || bus.res_data_o !== 32'h0FF0) begin bad++; $display("FAIL post_reset_first got v=%0b src=%0b d=%h want 1/1/00000ff0", bus.res_valid_o, bus.res_src_o, bus.res_data_o); end
  endtask

  task automatic test_single_xor();
    idle_clear();
    drive(0, 1, 2'b11, 32'hF0F0_1234, 32'h0F0F_FFFF, 4'd5);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    total++; if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 32'hFFFF_EDCB) begin bad++; $display("FAIL xor_data v=%0b got=%h want=ffffedcb", bus.res_valid_o, bus.res_data_o); end
    total++; if (bus.res_tag_o !== 4'd5 || bus.res_src_o !== 1'b0 || cnt0_o !== 2'd1) begin bad++; $display("FAIL xor_meta tag=%0d src=%0b cnt0=%0d want 5/0/1", bus.res_tag_o, bus.res_src_o, cnt0_o); end
  endtask

  task automatic test_not();
    drive(1, 1, 2'b10, 32'h0000_00FF, 32'hDEAD_BEEF, 4'd3);
    bus.res_ready_i = 1;
    tick();
    drive(1, 0, 0, 0, 0, 0);
    total++; if (bus.res_data_o !== 32'hFFFF_FF00 || bus.res_src_o !== 1'b1) begin bad++; $display("FAIL not_op got d=%h src=%0b want ffffff00/1", bus.res_data_o, bus.res_src_o); end
  endtask

  task automatic test_contention();
    idle_clear();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 2'($urandom_range(0, 3)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      drive(1, 1, 2'($urandom_range(0, 3)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      #1;
      total++; if ({bus.req1_ready_o, bus.req0_ready_o} !== ((i % 2) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL cont_ready[%0d] got=%b", i, {bus.req1_ready_o, bus.req0_ready_o}); end
      tick();
      total++; if (bus.res_valid_o !== 1'b1 || bus.res_src_o !== 1'(i % 2) || bus.res_data_o !== m_data) begin bad++; $display("FAIL cont_result[%0d] v=%0b src=%0b d=%h want src=%0d d=%h", i, bus.res_valid_o, bus.res_src_o, bus.res_data_o, i % 2, m_data); end
    end
    total++; if (cnt0_o !== 2'd3 || cnt1_o !== 2'd3) begin bad++; $display("FAIL cont_cnt got %0d/%0d want 3/3", cnt0_o, cnt1_o); end
  endtask

  task automatic test_backpressure();
    logic [31:0] hd; logic [3:0] ht; logic hs; int c0, c1; logic nxt;
    idle_clear();
    drive(0, 1, 2'b01, 32'h1111_0000, 32'h0000_2222, 4'd7);
    drive(1, 1, 2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'd8);
    tick();
    hd = m_data; ht = m_tag; hs = m_src; c0 = m_cnt0; c1 = m_cnt1;
    bus.res_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({bus.req0_ready_o, bus.req1_ready_o} !== 2'b00) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=00", i, {bus.req0_ready_o, bus.req1_ready_o}); end
      tick();
      total++; if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== hd || bus.res_tag_o !== ht || bus.res_src_o !== hs || cnt0_o !== 2'(c0) || cnt1_o !== 2'(c1)) begin bad++; $display("FAIL bp_hold[%0d] d=%h tag=%0d src=%0b cnt=%0d/%0d want %h/%0d/%0b/%0d/%0d", i, bus.res_data_o, bus.res_tag_o, bus.res_src_o, cnt0_o, cnt1_o, hd, ht, hs, c0, c1); end
    end
    bus.res_ready_i = 1;
    nxt = !hs;
    tick();
    total++; if (bus.res_valid_o !== 1'b1 || bus.res_src_o !== nxt || bus.res_data_o !== m_data) begin bad++; $display("FAIL bp_refill v=%0b src=%0b d=%h want 1/%0b/%h", bus.res_valid_o, bus.res_src_o, bus.res_data_o, nxt, m_data); end
    drive(0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_saturation();
    idle_clear();
    drive(0, 1, 2'b00, 32'hFFFF_FFFF, 32'h1234_5678, 4'd2);
    for (int i = 0; i < 5; i++) tick();
    total++; if (cnt0_o !== 2'd3) begin bad++; $display("FAIL sat_cnt0 got=%0d want=3", cnt0_o); end
    cnt_clr_i = 1;
    tick();
    cnt_clr_i = 0;
    total++; if (cnt0_o !== 2'd0 || bus.res_valid_o !== 1'b1) begin bad++; $display("FAIL clr_priority cnt0=%0d v=%0b want 0/1", cnt0_o, bus.res_valid_o); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.res_ready_i = ($urandom_range(0, 3) != 0);
      cnt_clr_i = ($urandom_range(0, 31) == 0);
      if (!(bus.req0_valid_i && !acc0))
        drive(0, $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      if (!(bus.req1_valid_i && !acc1))
        drive(1, $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      #1;
      total++; if (bus.req0_ready_o !== exp_ready(0) || bus.req1_ready_o !== exp_ready(1)) begin bad++; $display("FAIL rnd_ready[%0d] got=%b%b want=%b%b", i, bus.req0_ready_o, bus.req1_ready_o, exp_ready(0), exp_ready(1)); end
      tick();
      total++; if (bus.res_valid_o !== m_valid || bus.res_data_o !== m_data || bus.res_tag_o !== m_tag || bus.res_src_o !== m_src) begin bad++; $display("FAIL rnd_res[%0d] v=%0b d=%h t=%0d s=%0b want %0b/%h/%0d/%0b", i, bus.res_valid_o, bus.res_data_o, bus.res_tag_o, bus.res_src_o, m_valid, m_data, m_tag, m_src); end
      total++; if (cnt0_o !== 2'(m_cnt0) || cnt1_o !== 2'(m_cnt1)) begin bad++; $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d/%0d", i, cnt0_o, cnt1_o, m_cnt0, m_cnt1); end
    end
  endtask

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
    bus.res_ready_i = 0;
    test_reset();
    test_single_xor();
    test_not();
    test_contention();
    test_backpressure();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_logic_arbiter.md
Name: exec_logic_arbiter

Overview:
Shares one exec_logic unit (AND/OR/NOT/XOR) between two issue requesters using valid/ready handshakes and round-robin arbitration. The winning operation is evaluated combinationally and captured in a one-entry output register, tagged with the requester ID. The block sits between the issue stage and writeback. It also keeps saturating per-requester grant counters for performance monitoring.

Parameters:
W_OPR, 32, operand/result width
W_TAG, 4, requester-supplied destination tag width
W_CNT, 16, grant counter width (saturating)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid_i  input  1  requester 0 has an operation
req0_ready_o  output  1  requester 0 operation accepted this cycle
req0_opr0_i  input  W_OPR  requester 0 operand 0
req0_opr1_i  input  W_OPR  requester 0 operand 1
req0_select_i  input  2  requester 0 logic op
req0_tag_i  input  W_TAG  requester 0 destination tag
req1_valid_i, req1_ready_o, req1_opr0_i, req1_opr1_i, req1_select_i, req1_tag_i  same as requester 0, for requester 1
res_valid_o  output  1  result register holds a valid entry
res_ready_i  input  1  consumer accepts the result
res_data_o  output  W_OPR  registered result
res_tag_o  output  W_TAG  registered tag
res_src_o  output  1  requester ID that produced the result
cnt0_o  output  W_CNT  grants to requester 0
cnt1_o  output  W_CNT  grants to requester 1
cnt_clr_i  input  1  synchronous clear of both counters

Behaviour:
- Reset (rst_n low, asynchronous): res_valid_o=0; res_data_o, res_tag_o, res_src_o, cnt0_o, cnt1_o = 0; round-robin pointer rr=0 (requester 0 preferred). Both ready outputs are 0 while in reset.
- Op encoding (select): 00 AND, 01 OR, 10 NOT (~opr0, opr1 ignored), 11 XOR.
- can_accept = !res_valid_o | res_ready_i. A full register drains and refills in the same cycle, so throughput is 1 op/cycle.
- Grant (combinational):
  - Only req0 valid -> grant 0.
  - Only req1 valid -> grant 1.
  - Both valid -> grant rr.
  - reqN_ready_o = can_accept & (grant==N). At most one ready is high per cycle.
  - Ready must not depend on the requester's own valid through any path other than the grant logic.
- Transfer: when reqN_valid_i & reqN_ready_o at a rising edge:
  - res_data_o <= exec_logic(opr0, opr1, select), res_tag_o <= tag, res_src_o <= N, res_valid_o <= 1.
  - Latency is exactly 1 cycle from accept to res_valid_o.
- Drain without refill: res_valid_o & res_ready_i with no accept -> res_valid_o <= 0. Data outputs keep their last value.
- Hold: res_valid_o & !res_ready_i -> all res_* outputs are stable and both readies are 0.
- Requester rule: the requester holds operands, select and tag stable while valid & !ready. The block does not check this.
- rr update: rr <= !N only when a transfer for N occurs while both requesters were valid. Otherwise rr is unchanged. Under continuous dual requests, grants strictly alternate, bounding wait to 1 transfer.
- Counters: cntN increments on each transfer for N and saturates at 2^W_CNT-1. cnt_clr_i has priority over an increment in the same cycle (result 0).
- Reset mid-operation: any in-flight result is discarded and counters clear. No transfer is reported for an accept edge coincident with reset assertion.

Decomposition:
- Shared package/include: op encodings (OP_AND=2'b00, OP_OR=2'b01, OP_NOT=2'b10, OP_XOR=2'b11), W_OPR default, requester ID constants.
- Sub-module: instantiate existing exec_logic as the datapath, fed by a 2:1 operand/select mux driven by grant.
- Arbitration, output register and counters stay in this module, roughly 150-200 lines.

Test Plan:
- Reset: assert rst_n=0 mid-stream with res_valid_o=1 -> res_valid_o=0, cnt0_o=cnt1_o=0, readies 0 immediately; after release, req1-only request is granted first cycle.
- Single op (W_OPR=32): req0 XOR, opr0=32'hF0F0_1234, opr1=32'h0F0F_FFFF, tag=5 -> next cycle res_valid_o=1, res_data_o=32'hFFFF_EDCB, res_tag_o=5, res_src_o=0, cnt0_o=1.
- NOT ignores opr1: req1 select=10, opr0=32'h0000_00FF, opr1=32'hDEAD_BEEF -> res_data_o=32'hFFFF_FF00, res_src_o=1.
- Contention: both valid for 6 cycles, res_ready_i=1 -> grants 0,1,0,1,0,1; cnt0_o=3, cnt1_o=3; one result per cycle.
- Backpressure: res_ready_i=0 for 3 cycles with both valid -> res_* held stable, both readies 0, counters frozen; res_ready_i=1 -> drain and refill in same cycle, next grant follows rr.
- Counter saturation/clear: W_CNT=2, 5 req0 transfers -> cnt0_o=3; cnt_clr_i with concurrent transfer -> cnt0_o=0.
